// File: rtl/shift_left_norm_if.sv
// Handshake bundle for shift_left_norm: upstream value/valid/ready and downstream result/valid/ready.
interface shift_left_norm_if #(
   parameter int N = 16,
   parameter int S = 4
);
   logic [N-1:0] a;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] c;
   logic [S-1:0] lzc;
   logic         zero;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output a, in_valid, out_ready,
      input  in_ready, c, lzc, zero, out_valid
   );

   modport slave (
      input  a, in_valid, out_ready,
      output in_ready, c, lzc, zero, out_valid
   );
endinterface

// File: rtl/shift_left_norm.sv
// Elastic left-normalizer: c = a << lzc with lzc the leading-zero count, zero flags a == 0.
// SHIFT_LEFT_NORM_PIPELINE_EN defined: one slot per stage (latency S); undefined: one output slot (latency 1).
module shift_left_norm #(
   parameter int N = 16,
   parameter int S = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_left_norm_if.slave bus
);
`ifdef SHIFT_LEFT_NORM_PIPELINE_EN
   localparam int NSLOT = S;
`else
   localparam int NSLOT = 1;
`endif

   logic [NSLOT-1:0] vld_q, vld_d;
   logic [NSLOT-1:0] zero_q, zero_d;
   logic [N-1:0]     v_q   [NSLOT];
   logic [N-1:0]     v_d   [NSLOT];
   logic [S-1:0]     cnt_q [NSLOT];
   logic [S-1:0]     cnt_d [NSLOT];

   logic [NSLOT:0]   rdy;
   logic [NSLOT-1:0] src_vld, src_zero;
   logic [N-1:0]     src_v   [NSLOT];
   logic [S-1:0]     src_cnt [NSLOT];
   logic [N-1:0]     nv;
   logic [S-1:0]     ncnt;
   logic             load;

   // Stage k tests the top 2**(S-1-k) bits of the running value.
   function automatic logic stage_hit(input logic [N-1:0] v, input int k);
      return (v >> (N - (1 << (S - 1 - k)))) == '0;
   endfunction

   function automatic logic [N-1:0] stage_v(input logic [N-1:0] v, input int k);
      return stage_hit(v, k) ? (v << (1 << (S - 1 - k))) : v;
   endfunction

   // A zero input would hit every stage; its count is forced to stay 0.
   function automatic logic [S-1:0] stage_cnt(input logic [N-1:0] v, input logic [S-1:0] cnt,
                                              input logic zero, input int k);
      return (stage_hit(v, k) && !zero) ? (cnt | (S'(1) << (S - 1 - k))) : cnt;
   endfunction

   always_comb begin
      rdy      = '0;
      src_vld  = '0;
      src_zero = '0;
      src_v    = '{default: '0};
      src_cnt  = '{default: '0};
      vld_d    = vld_q;
      zero_d   = zero_q;
      v_d      = v_q;
      cnt_d    = cnt_q;
      nv       = '0;
      ncnt     = '0;
      load     = 1'b0;

      // A slot may load when it is empty or the slot after it can take its beat.
      rdy[NSLOT] = bus.out_ready;
      for (int k = NSLOT - 1; k >= 0; k--)
         rdy[k] = !vld_q[k] || rdy[k+1];

      src_vld[0]  = bus.in_valid;
      src_v[0]    = bus.a;
      src_cnt[0]  = '0;
      src_zero[0] = (bus.a == '0);
      for (int k = 1; k < NSLOT; k++) begin
         src_vld[k]  = vld_q[k-1];
         src_v[k]    = v_q[k-1];
         src_cnt[k]  = cnt_q[k-1];
         src_zero[k] = zero_q[k-1];
      end

      for (int k = 0; k < NSLOT; k++) begin
         nv   = src_v[k];
         ncnt = src_cnt[k];
`ifdef SHIFT_LEFT_NORM_PIPELINE_EN
         ncnt = stage_cnt(nv, ncnt, src_zero[k], k);
         nv   = stage_v(nv, k);
`else
         for (int j = 0; j < S; j++) begin
            ncnt = stage_cnt(nv, ncnt, src_zero[k], j);
            nv   = stage_v(nv, j);
         end
`endif
         load      = rdy[k] && src_vld[k];
         vld_d[k]  = rdy[k] ? src_vld[k] : vld_q[k];
         v_d[k]    = load ? nv : v_q[k];
         cnt_d[k]  = load ? ncnt : cnt_q[k];
         zero_d[k] = load ? src_zero[k] : zero_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   // Only the output slot's data is cleared so the visible result reads 0 after reset.
   always_ff @(posedge clk) begin
      v_q    <= v_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      if (!rst_n) begin
         v_q[NSLOT-1]    <= '0;
         cnt_q[NSLOT-1]  <= '0;
         zero_q[NSLOT-1] <= 1'b0;
      end
   end

   assign bus.in_ready  = rst_n && rdy[0];
   assign bus.out_valid = vld_q[NSLOT-1];
   assign bus.c         = v_q[NSLOT-1];
   assign bus.lzc       = cnt_q[NSLOT-1];
   assign bus.zero      = zero_q[NSLOT-1];
endmodule

// File: tb/tb_shift_left_norm.sv
// Directed-table and random bench for shift_left_norm with an in-order result queue.
module tb_shift_left_norm;
   localparam int N = 16;
   localparam int S = 4;
`ifdef SHIFT_LEFT_NORM_PIPELINE_EN
   localparam int NSLOT = S;
   localparam int LAT   = S;
`else
   localparam int NSLOT = 1;
   localparam int LAT   = 1;
`endif
   localparam int INFLIGHT = (NSLOT < 3) ? NSLOT : 3;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] c;
      logic [S-1:0] lzc;
      logic         zero;
   } vec_t;

   logic clk;
   logic rst_n;
   shift_left_norm_if #(.N(N), .S(S)) bus ();

   shift_left_norm #(.N(N), .S(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   occ = 0;
   int   n_del = 0;
   int   del_cyc = 0;
   int   acc_cyc = 0;
   bit   prev_stall = 0;
   bit   saw_low = 0;
   logic [N+S:0] hold;
   vec_t cur;
   vec_t exp_q[$];
   vec_t tbl[10];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t model(input logic [N-1:0] x);
      vec_t m;
      int z;
      m.a = x;
      m.zero = (x == '0);
      m.lzc = '0;
      m.c = '0;
      if (x != '0) begin
         z = 0;
         while (x[N-1-z] == 1'b0) z++;
         m.lzc = S'(z);
         m.c = x << z;
      end
      return m;
   endfunction

   // Monitor samples 2 time units after the falling edge, when inputs and outputs are settled.
   always @(negedge clk) begin
      vec_t e;
      #2;
      if (!rst_n) begin
         check("in_ready_in_reset", bus.in_ready, 0);
         exp_q.delete();
         occ = 0;
         prev_stall = 0;
      end else begin
         check("in_ready", bus.in_ready, (occ < NSLOT) || bus.out_ready);
         if (!bus.in_ready) saw_low = 1;
         if (prev_stall)
            check("hold_stable", {bus.out_valid, bus.c, bus.lzc, bus.zero}, {1'b1, hold});
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", {bus.c, bus.lzc, bus.zero}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("result", {bus.c, bus.lzc, bus.zero}, {e.c, e.lzc, e.zero});
            end
            n_del++;
            del_cyc = cyc;
            occ--;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         hold = {bus.c, bus.lzc, bus.zero};
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(cur);
            occ++;
            acc_cyc = cyc;
         end
      end
   end

   task automatic send(input vec_t v);
      bit done = 0;
      bus.a = v.a;
      cur = v;
      bus.in_valid = 1;
      for (int i = 0; i < 50 && !done; i++) begin
         #3;
         done = bus.in_ready;
         @(negedge clk);
      end
      check("send_accept", done, 1);
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      int d0, a0, sent;
      bit acc;
      logic [31:0] r;

      tbl[0] = '{16'h00F0, 16'hF000, 4'd8,  1'b0};
      tbl[1] = '{16'h8000, 16'h8000, 4'd0,  1'b0};
      tbl[2] = '{16'h0000, 16'h0000, 4'd0,  1'b1};
      tbl[3] = '{16'h0300, 16'hC000, 4'd6,  1'b0};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 4'd0,  1'b0};
      tbl[5] = '{16'h1234, 16'h91A0, 4'd3,  1'b0};
      tbl[6] = '{16'h0080, 16'h8000, 4'd8,  1'b0};
      tbl[7] = '{16'h7FFF, 16'hFFFE, 4'd1,  1'b0};
      tbl[8] = '{16'h0003, 16'hC000, 4'd14, 1'b0};
      tbl[9] = '{16'h0001, 16'h8000, 4'd15, 1'b0};

      rst_n = 0;
      bus.in_valid = 0;
      bus.a = '0;
      bus.out_ready = 0;
      cur = tbl[0];

      // Reset state.
      repeat (2) @(negedge clk);
      #3;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_c", bus.c, 0);
      check("rst_lzc", bus.lzc, 0);
      check("rst_zero", bus.zero, 0);
      @(negedge clk);
      rst_n = 1;
      #3;
      check("in_ready_after_release", bus.in_ready, 1);
      @(negedge clk);

      // Single beat latency.
      bus.out_ready = 1;
      d0 = n_del;
      send(tbl[9]);
      bus.in_valid = 0;
      for (int i = 0; i < 20 && n_del == d0; i++) @(negedge clk);
      check("single_delivered", n_del - d0, 1);
      check("single_latency", del_cyc - acc_cyc, LAT);

      // Back-to-back table stream.
      d0 = n_del;
      send(tbl[0]);
      a0 = acc_cyc;
      for (int i = 1; i < 10; i++) send(tbl[i]);
      bus.in_valid = 0;
      drain(50);
      check("stream_count", n_del - d0, 10);
      check("stream_span", del_cyc - a0, LAT + 9);

      // Backpressure: out_ready low on cycles 3..8 of a 10-beat stream.
      d0 = n_del;
      sent = 0;
      saw_low = 0;
      for (int k = 0; k < 60 && (sent < 10 || k < 12); k++) begin
         bus.out_ready = !(k >= 3 && k <= 8);
         bus.in_valid = (sent < 10);
         bus.a = N'(sent + 1);
         cur = model(N'(sent + 1));
         #3;
         if (bus.in_valid && bus.in_ready) sent++;
         @(negedge clk);
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      drain(50);
      check("bp_sent", sent, 10);
      check("bp_count", n_del - d0, 10);
      check("bp_in_ready_fell", saw_low, 1);

      // Reset with beats in flight.
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1;
         bus.a = 16'h0010 << i;
         cur = model(16'h0010 << i);
         @(negedge clk);
      end
      bus.in_valid = 0;
      check("inflight_before_rst", exp_q.size(), INFLIGHT);
      d0 = n_del;
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      #3;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_c", bus.c, 0);
      check("midrst_lzc", bus.lzc, 0);
      check("midrst_zero", bus.zero, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.out_ready = 1;
      repeat (12) @(negedge clk);
      check("midrst_no_output", n_del - d0, 0);

      // Random traffic against the reference model.
      d0 = n_del;
      sent = 0;
      acc = 0;
      for (int k = 0; k < 60000 && sent < 10000; k++) begin
         if (!bus.in_valid || acc) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            if (bus.in_valid) begin
               r = $urandom();
               bus.a = r[15:0] >> $urandom_range(0, 16);
               cur = model(bus.a);
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #3;
         acc = bus.in_valid && bus.in_ready;
         if (acc) sent++;
         @(negedge clk);
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      drain(100);
      check("rand_sent", sent, 10000);
      check("rand_count", n_del - d0, sent);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/shift_left_norm.md
# shift_left_norm

Pipelined left-normalizer, the inverse direction of the team's right-shift alignment stage. It takes an N-bit significand, counts leading zeros, and shifts the value left until its MSB is 1, producing both the normalized value and the shift amount for exponent adjustment. It sits after the accumulate/add stage of the arithmetic datapath and in front of rounding/encoding. It has a valid/ready handshake with full backpressure.

## Interface
- N, 16, data width; must satisfy 2**(S-1) < N <= 2**S
- S, 4, shift-count width; also the number of normalization stages
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- a  in  N  value to normalize
- in_valid  in  1  a is valid
- in_ready  out  1  block can accept a this cycle
- c  out  N  normalized value, c = a << lzc
- lzc  out  S  number of leading zeros of a
- zero  out  1  a was all zeros
- out_valid  out  1  c/lzc/zero valid
- out_ready  in  1  downstream accepts this cycle

## Operation
- Normalization stage k (k = 0..S-1) uses shift amount d = 2**(S-1-k) and acts on the running value v:
  - if the top d bits of v are all 0: v <= v << d (zero-fill) and bit (S-1-k) of the count is 1
  - otherwise v is unchanged and the count bit is 0
- After S stages: c = v, lzc = the accumulated count.
- a == 0: c = 0, lzc = 0, zero = 1. Otherwise zero = 0 and c[N-1] = 1.
- Each stage is a slot holding valid + value + partial count + zero flag.
- Elastic pipeline:
  - A slot loads from its predecessor when the slot is empty or is emptying this cycle.
  - The last slot empties when out_valid && out_ready.
  - in_ready = first slot empty, or first slot advancing this cycle. This is combinational from slot state and out_ready; there is no path from in_valid to in_ready.
- A transfer happens on a cycle where valid && ready are both 1. The beat order is preserved, and nothing is dropped or duplicated.
- While out_valid = 1 and out_ready = 0, c/lzc/zero hold stable.
- Arithmetic: the count is an unsigned S-bit sum of disjoint powers of two, so it cannot overflow. The shift is logical, and bits shifted past the MSB are always zeros.

## Timing
- Reset (rst_n low at a clock edge) empties every slot:
  - out_valid = 0, c = 0, lzc = 0, zero = 0
  - in_ready = 0 while rst_n is low
  - in_ready = 1 on the first cycle after release
- Reset mid-operation discards all in-flight beats and produces no partial output.
- Pipelined build: latency is S cycles from input acceptance to out_valid, with no stalls. Throughput is 1 beat per cycle with out_ready held high.
- Backpressure: with out_ready low, the pipeline fills. in_ready drops once all S slots are full, and does so combinationally in the same cycle the last slot fills.
- Simultaneous output drain and input accept in a full pipeline: all slots advance and in_ready stays 1.
- out_valid, c, lzc and zero come directly from registers.

## Configuration
- SHIFT_LEFT_NORM_PIPELINE_EN defined:
  - one register slot per stage (S slots)
  - latency S
- SHIFT_LEFT_NORM_PIPELINE_EN undefined:
  - all S stages are combinational, followed by one output slot
  - latency 1
  - in_ready = !out_valid || out_ready
- Functional results are identical in both builds; only latency and the fill depth differ.

## Test plan
- a=16'h0001, single beat, out_ready=1 -> c=16'h8000, lzc=4'd15, zero=0; out_valid exactly S cycles after accept (1 cycle in the unpipelined build).
- Back-to-back stream a=16'h00F0, 16'h8000, 16'h0000, 16'h0300 -> (16'hF000, 8, 0), (16'h8000, 0, 0), (16'h0000, 0, 1), (16'hC000, 6, 0), in order, one per cycle.
- Stream of 10 incrementing values, out_ready low for cycles 3..8:
  - in_ready falls when S slots are full
  - outputs hold stable while stalled
  - all 10 results delivered in order, with no loss or duplication
- Reset pulse (rst_n=0 for 1 cycle) with 3 beats in flight -> out_valid=0, c=0, lzc=0, zero=0 next cycle; none of the 3 beats ever appear; in_ready=1 after release.
- Random a over 10k beats with random out_ready, checked against a reference count-leading-zeros model -> c == a << lzc, c[N-1]==1 for a!=0, order preserved. Run in both macro builds, and with N=12, S=4.
